// File: rtl/wb_port_arbiter_pkg.sv
// Shared definitions for the register-file write-port arbiter: default widths,
// FSM state encoding and a counter-width helper.
package wb_port_arbiter_pkg;

   localparam int DATA_W_DEF   = 32;
   localparam int IMM_W_DEF    = 19;
   localparam int RA_W_DEF     = 5;
   localparam int MAX_WAIT_DEF = 3;

   // IDLE: no immediate parked; HOLD: one immediate waits in the hold buffer.
   typedef enum logic {
      IDLE = 1'b0,
      HOLD = 1'b1
   } arb_state_e;

   // Bits needed to count 0..max_val inclusive (at least one bit).
   function automatic int cnt_width(input int max_val);
      return (max_val < 1) ? 1 : $clog2(max_val + 1);
   endfunction

endpackage

// File: rtl/wb_port_arbiter_sign_ext.sv
// Two's-complement sign extension from INSIZE to OUTSIZE bits.
module sign_ext #(
   parameter int INSIZE  = 19,
   parameter int OUTSIZE = 32
) (
   input  logic signed [INSIZE-1:0]  din,
   output logic signed [OUTSIZE-1:0] dout
);

   // Replicate the sign bit into the upper bits.
   always_comb begin
      dout = {{(OUTSIZE-INSIZE){din[INSIZE-1]}}, din};
   end

endmodule

// File: rtl/wb_port_arbiter.sv
// Register-file write-port arbiter between the ALU result path and the
// immediate-load path. A same-cycle conflict to different registers parks the
// immediate in a one-entry hold buffer; the ALU keeps priority until the
// immediate has been deferred MAX_WAIT times, then the ALU is stalled once so
// the held write drains. A younger ALU write to the held register supersedes it.
module wb_port_arbiter
   import wb_port_arbiter_pkg::*;
#(
   parameter int DATA_W   = DATA_W_DEF,
   parameter int IMM_W    = IMM_W_DEF,
   parameter int RA_W     = RA_W_DEF,
   parameter int MAX_WAIT = MAX_WAIT_DEF
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              alu_valid,
   output logic              alu_ready,
   input  logic [RA_W-1:0]   alu_rd,
   input  logic [DATA_W-1:0] alu_data,
   input  logic              imm_valid,
   output logic              imm_ready,
   input  logic [RA_W-1:0]   imm_rd,
   input  logic [IMM_W-1:0]  imm_data,
   output logic              rf_we,
   output logic [RA_W-1:0]   rf_waddr,
   output logic [DATA_W-1:0] rf_wdata,
   output logic              drop_pulse
);

   localparam int              CNT_W    = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] WAIT_LIM = CNT_W'(MAX_WAIT);

   arb_state_e               state;
   arb_state_e               state_nx;
   logic [RA_W-1:0]          hold_rd;
   logic signed [DATA_W-1:0] hold_data;
   logic [CNT_W-1:0]         wait_cnt;
   logic [CNT_W-1:0]         wait_nx;
   logic signed [DATA_W-1:0] imm_ext;
   logic                     alu_xfer;
   logic                     imm_xfer;
   logic                     hold_ld;
   logic                     vld_p0;
   logic [RA_W-1:0]          wr_addr_p0;
   logic signed [DATA_W-1:0] wr_data_p0;
   logic                     drop_p0;

   // Deferral counter increment that never wraps past MAX_WAIT.
   function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
      return (v == WAIT_LIM) ? v : v + CNT_W'(1);
   endfunction

   // The hold buffer stores the already-extended value.
   sign_ext #(
      .INSIZE  (IMM_W),
      .OUTSIZE (DATA_W)
   ) u_sext (
      .din  (imm_data),
      .dout (imm_ext)
   );

   assign alu_xfer = alu_valid && alu_ready;
   assign imm_xfer = imm_valid && imm_ready;

   // FSM state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= state_nx;
      end
   end

   // Grant, next-state and write-select decision for the upcoming cycle.
   always_comb begin
      state_nx   = state;
      vld_p0     = 1'b0;
      wr_addr_p0 = alu_rd;
      wr_data_p0 = alu_data;
      drop_p0    = 1'b0;
      hold_ld    = 1'b0;
      wait_nx    = wait_cnt;
      case (state)
         IDLE: begin
            if (alu_xfer) begin
               // ALU is the younger request and always wins the port.
               vld_p0 = 1'b1;
               if (imm_xfer) begin
                  if (alu_rd == imm_rd) begin
                     drop_p0 = 1'b1;
                  end else begin
                     hold_ld  = 1'b1;
                     wait_nx  = '0;
                     state_nx = HOLD;
                  end
               end
            end else if (imm_xfer) begin
               vld_p0     = 1'b1;
               wr_addr_p0 = imm_rd;
               wr_data_p0 = imm_ext;
            end
         end
         HOLD: begin
            if (alu_xfer) begin
               vld_p0 = 1'b1;
               if (alu_rd == hold_rd) begin
                  // Younger ALU write makes the parked immediate dead.
                  drop_p0  = 1'b1;
                  wait_nx  = '0;
                  state_nx = IDLE;
               end else begin
                  wait_nx = sat_inc(wait_cnt);
               end
            end else begin
               vld_p0     = 1'b1;
               wr_addr_p0 = hold_rd;
               wr_data_p0 = hold_data;
               wait_nx    = '0;
               state_nx   = IDLE;
            end
         end
         default: begin
            state_nx = IDLE;
         end
      endcase
   end

   // Handshake readies decoded from the current state.
   always_comb begin
      imm_ready = (state == IDLE);
      alu_ready = !((state == HOLD) && (wait_cnt == WAIT_LIM));
   end

   // Register-file write stage, hold buffer and deferral counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         rf_we      <= 1'b0;
         rf_waddr   <= '0;
         rf_wdata   <= '0;
         drop_pulse <= 1'b0;
         hold_rd    <= '0;
         hold_data  <= '0;
         wait_cnt   <= '0;
      end else begin
         // Writes to r0 complete the handshake but never reach the file.
         rf_we <= vld_p0 && (wr_addr_p0 != '0);
         if (vld_p0 && (wr_addr_p0 != '0)) begin
            rf_waddr <= wr_addr_p0;
            rf_wdata <= wr_data_p0;
         end
         drop_pulse <= drop_p0;
         wait_cnt   <= wait_nx;
         if (hold_ld) begin
            hold_rd   <= imm_rd;
            hold_data <= imm_ext;
         end
      end
   end

endmodule

// File: tb/tb_wb_port_arbiter.sv
// Self-checking bench for wb_port_arbiter: directed scenarios plus a
// randomized run against a queue-based reference model.
module tb_wb_port_arbiter;

   localparam int DATA_W   = 32;
   localparam int IMM_W    = 19;
   localparam int RA_W     = 5;
   localparam int MAX_WAIT = 3;

   typedef struct {
      logic [RA_W-1:0]   rd;
      logic [DATA_W-1:0] data;
   } wr_t;

   logic              clk = 1'b0;
   logic              rst_n = 1'b0;
   logic              alu_valid = 1'b0;
   logic              alu_ready;
   logic [RA_W-1:0]   alu_rd = '0;
   logic [DATA_W-1:0] alu_data = '0;
   logic              imm_valid = 1'b0;
   logic              imm_ready;
   logic [RA_W-1:0]   imm_rd = '0;
   logic [IMM_W-1:0]  imm_data = '0;
   logic              rf_we;
   logic [RA_W-1:0]   rf_waddr;
   logic [DATA_W-1:0] rf_wdata;
   logic              drop_pulse;

   int checks = 0;
   int errors = 0;

   wb_port_arbiter #(
      .DATA_W   (DATA_W),
      .IMM_W    (IMM_W),
      .RA_W     (RA_W),
      .MAX_WAIT (MAX_WAIT)
   ) dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .alu_valid  (alu_valid),
      .alu_ready  (alu_ready),
      .alu_rd     (alu_rd),
      .alu_data   (alu_data),
      .imm_valid  (imm_valid),
      .imm_ready  (imm_ready),
      .imm_rd     (imm_rd),
      .imm_data   (imm_data),
      .rf_we      (rf_we),
      .rf_waddr   (rf_waddr),
      .rf_wdata   (rf_wdata),
      .drop_pulse (drop_pulse)
   );

   always #5 clk = ~clk;

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // Two's-complement value of a 19-bit immediate, as plain integer arithmetic.
   function automatic logic [DATA_W-1:0] sext_model(input logic [IMM_W-1:0] v);
      longint s;
      s = longint'(v);
      if (s >= (longint'(1) << (IMM_W - 1))) s = s - (longint'(1) << IMM_W);
      return DATA_W'(s);
   endfunction

   task automatic drive(input logic av, input logic [RA_W-1:0] ard, input logic [DATA_W-1:0] ad,
                        input logic iv, input logic [RA_W-1:0] ird, input logic [IMM_W-1:0] id);
      alu_valid = av;
      alu_rd    = ard;
      alu_data  = ad;
      imm_valid = iv;
      imm_rd    = ird;
      imm_data  = id;
   endtask

   task automatic idle();
      drive(1'b0, '0, '0, 1'b0, '0, '0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      idle();
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b1;
   endtask

   task automatic test_reset();
      idle();
      #2;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_init_we got %0b exp 0", rf_we); end
      checks++; if (rf_waddr !== 5'd0) begin errors++; $display("FAIL rst_init_waddr got %0d exp 0", rf_waddr); end
      checks++; if (rf_wdata !== 32'd0) begin errors++; $display("FAIL rst_init_wdata got %h exp 0", rf_wdata); end
      checks++; if (alu_ready !== 1'b1 || imm_ready !== 1'b1) begin errors++; $display("FAIL rst_init_ready got %0b%0b exp 11", alu_ready, imm_ready); end
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      // Same-rd conflict raises drop_pulse, then a different-rd conflict parks an immediate.
      drive(1'b1, 5'd5, 32'h1, 1'b1, 5'd5, 19'h2);
      tick();
      checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL rst_pre_drop got %0b exp 1", drop_pulse); end
      drive(1'b1, 5'd1, 32'h10, 1'b1, 5'd2, 19'h20);
      tick();
      drive(1'b1, 5'd1, 32'h30, 1'b0, '0, '0);
      #3;
      rst_n = 1'b0;
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_async_we got %0b exp 0", rf_we); end
      checks++; if (drop_pulse !== 1'b0) begin errors++; $display("FAIL rst_async_drop got %0b exp 0", drop_pulse); end
      checks++; if (alu_ready !== 1'b1 || imm_ready !== 1'b1) begin errors++; $display("FAIL rst_async_ready got %0b%0b exp 11", alu_ready, imm_ready); end
      repeat (2) @(posedge clk);
      #1;
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_held_we got %0b exp 0", rf_we); end
      rst_n = 1'b1;
      idle();
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL rst_hold_discard_we got %0b exp 0", rf_we); end
   endtask

   task automatic test_imm_only();
      drive(1'b0, '0, '0, 1'b1, 5'd7, 19'h40000);
      #1;
      checks++; if (imm_ready !== 1'b1) begin errors++; $display("FAIL imm_ready got %0b exp 1", imm_ready); end
      tick();
      checks++; if (rf_we !== 1'b1) begin errors++; $display("FAIL imm_we got %0b exp 1", rf_we); end
      checks++; if (rf_waddr !== 5'd7) begin errors++; $display("FAIL imm_waddr got %0d exp 7", rf_waddr); end
      checks++; if (rf_wdata !== 32'hFFFC0000) begin errors++; $display("FAIL imm_wdata got %h exp fffc0000", rf_wdata); end
      idle();
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL imm_idle_we got %0b exp 0", rf_we); end
      checks++; if (rf_waddr !== 5'd7 || rf_wdata !== 32'hFFFC0000) begin errors++; $display("FAIL imm_idle_keep got %0d/%h exp 7/fffc0000", rf_waddr, rf_wdata); end
   endtask

   task automatic test_conflict();
      drive(1'b1, 5'd3, 32'h11, 1'b1, 5'd4, 19'h00005);
      #1;
      checks++; if (alu_ready !== 1'b1 || imm_ready !== 1'b1) begin errors++; $display("FAIL cfl_ready got %0b%0b exp 11", alu_ready, imm_ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'h11) begin errors++; $display("FAIL cfl_alu_wr got %0b/%0d/%h exp 1/3/11", rf_we, rf_waddr, rf_wdata); end
      idle();
      #1;
      checks++; if (imm_ready !== 1'b0) begin errors++; $display("FAIL cfl_imm_stall got %0b exp 0", imm_ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd4 || rf_wdata !== 32'h5) begin errors++; $display("FAIL cfl_hold_wr got %0b/%0d/%h exp 1/4/5", rf_we, rf_waddr, rf_wdata); end
      checks++; if (imm_ready !== 1'b1) begin errors++; $display("FAIL cfl_imm_back got %0b exp 1", imm_ready); end
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL cfl_after_we got %0b exp 0", rf_we); end
   endtask

   task automatic test_same_rd();
      drive(1'b1, 5'd9, 32'hABCD, 1'b1, 5'd9, 19'h123);
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd9 || rf_wdata !== 32'hABCD) begin errors++; $display("FAIL same_wr got %0b/%0d/%h exp 1/9/abcd", rf_we, rf_waddr, rf_wdata); end
      checks++; if (drop_pulse !== 1'b1) begin errors++; $display("FAIL same_drop got %0b exp 1", drop_pulse); end
      idle();
      tick();
      checks++; if (drop_pulse !== 1'b0 || rf_we !== 1'b0) begin errors++; $display("FAIL same_after got drop %0b we %0b exp 0 0", drop_pulse, rf_we); end
   endtask

   task automatic test_starvation();
      drive(1'b1, 5'd1, 32'hA0, 1'b1, 5'd2, 19'h7FFFF);
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd1 || rf_wdata !== 32'hA0) begin errors++; $display("FAIL starve_first got %0b/%0d/%h exp 1/1/a0", rf_we, rf_waddr, rf_wdata); end
      for (int k = 1; k <= 3; k++) begin
         drive(1'b1, 5'd3, 32'hA0 + k, 1'b0, '0, '0);
         #1;
         checks++; if (alu_ready !== 1'b1 || imm_ready !== 1'b0) begin errors++; $display("FAIL starve_ready%0d got %0b%0b exp 10", k, alu_ready, imm_ready); end
         tick();
         checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hA0 + k) begin errors++; $display("FAIL starve_alu%0d got %0b/%0d/%h exp 1/3/%h", k, rf_we, rf_waddr, rf_wdata, 32'hA0 + k); end
      end
      drive(1'b1, 5'd3, 32'hB0, 1'b0, '0, '0);
      #1;
      checks++; if (alu_ready !== 1'b0) begin errors++; $display("FAIL starve_stall got %0b exp 0", alu_ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd2 || rf_wdata !== 32'hFFFFFFFF) begin errors++; $display("FAIL starve_hold_wr got %0b/%0d/%h exp 1/2/ffffffff", rf_we, rf_waddr, rf_wdata); end
      #1;
      checks++; if (alu_ready !== 1'b1 || imm_ready !== 1'b1) begin errors++; $display("FAIL starve_idle got %0b%0b exp 11", alu_ready, imm_ready); end
      tick();
      checks++; if (rf_we !== 1'b1 || rf_waddr !== 5'd3 || rf_wdata !== 32'hB0) begin errors++; $display("FAIL starve_resume got %0b/%0d/%h exp 1/3/b0", rf_we, rf_waddr, rf_wdata); end
      idle();
      tick();
   endtask

   task automatic test_r0();
      drive(1'b1, 5'd6, 32'h66, 1'b0, '0, '0);
      tick();
      drive(1'b1, 5'd0, 32'h55, 1'b0, '0, '0);
      #1;
      checks++; if (alu_ready !== 1'b1) begin errors++; $display("FAIL r0_ready got %0b exp 1", alu_ready); end
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_we got %0b exp 0", rf_we); end
      checks++; if (rf_waddr !== 5'd6 || rf_wdata !== 32'h66) begin errors++; $display("FAIL r0_keep got %0d/%h exp 6/66", rf_waddr, rf_wdata); end
      drive(1'b0, '0, '0, 1'b1, 5'd0, 19'h1);
      tick();
      checks++; if (rf_we !== 1'b0) begin errors++; $display("FAIL r0_imm_we got %0b exp 0", rf_we); end
      idle();
   endtask

   task automatic test_random();
      wr_t               held[$];
      int                defer;
      logic              av, iv, ax, ix, do_wr, exp_we, exp_drop, exp_ar, exp_ir;
      logic [RA_W-1:0]   ard, ird, wr_rd, exp_addr;
      logic [DATA_W-1:0] ad, wr_d, exp_data;
      logic [IMM_W-1:0]  id;
      wr_t               h;
      do_reset();
      held.delete();
      defer    = 0;
      exp_addr = '0;
      exp_data = '0;
      for (int n = 0; n < 600; n++) begin
         av  = ($urandom_range(0, 3) != 0);
         ard = RA_W'($urandom_range(0, 3));
         ad  = $urandom;
         iv  = ($urandom_range(0, 1) != 0);
         ird = RA_W'($urandom_range(0, 3));
         id  = IMM_W'($urandom);
         drive(av, ard, ad, iv, ird, id);
         #1;
         exp_ir = (held.size() == 0);
         exp_ar = !((held.size() != 0) && (defer == MAX_WAIT));
         checks++; if (imm_ready !== exp_ir) begin errors++; $display("FAIL rnd_imm_ready n=%0d got %0b exp %0b", n, imm_ready, exp_ir); end
         checks++; if (alu_ready !== exp_ar) begin errors++; $display("FAIL rnd_alu_ready n=%0d got %0b exp %0b", n, alu_ready, exp_ar); end
         ax       = av && exp_ar;
         ix       = iv && exp_ir;
         do_wr    = 1'b0;
         wr_rd    = '0;
         wr_d     = '0;
         exp_drop = 1'b0;
         if (held.size() == 0) begin
            if (ax) begin
               do_wr = 1'b1; wr_rd = ard; wr_d = ad;
               if (ix && ard == ird) begin
                  exp_drop = 1'b1;
               end else if (ix) begin
                  h.rd = ird; h.data = sext_model(id);
                  held.push_back(h);
                  defer = 0;
               end
            end else if (ix) begin
               do_wr = 1'b1; wr_rd = ird; wr_d = sext_model(id);
            end
         end else begin
            if (ax) begin
               do_wr = 1'b1; wr_rd = ard; wr_d = ad;
               if (ard == held[0].rd) begin
                  exp_drop = 1'b1;
                  held.delete();
               end else if (defer < MAX_WAIT) begin
                  defer++;
               end
            end else begin
               h = held.pop_front();
               do_wr = 1'b1; wr_rd = h.rd; wr_d = h.data;
            end
         end
         exp_we = do_wr && (wr_rd != 0);
         if (exp_we) begin
            exp_addr = wr_rd;
            exp_data = wr_d;
         end
         tick();
         checks++; if (rf_we !== exp_we) begin errors++; $display("FAIL rnd_we n=%0d got %0b exp %0b", n, rf_we, exp_we); end
         checks++; if (rf_waddr !== exp_addr) begin errors++; $display("FAIL rnd_waddr n=%0d got %0d exp %0d", n, rf_waddr, exp_addr); end
         checks++; if (rf_wdata !== exp_data) begin errors++; $display("FAIL rnd_wdata n=%0d got %h exp %h", n, rf_wdata, exp_data); end
         checks++; if (drop_pulse !== exp_drop) begin errors++; $display("FAIL rnd_drop n=%0d got %0b exp %0b", n, drop_pulse, exp_drop); end
      end
      idle();
   endtask

   initial begin
      test_reset();
      test_imm_only();
      test_conflict();
      test_same_rd();
      test_starvation();
      test_r0();
      test_random();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
